// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection for the 5-stage MIPS core.
// Build option: define FWD_EN for EX/MEM + MEM/WB forwarding; undefined, RAW on EX or EX/MEM stalls instead.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    // decoded instruction from ID
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [2:0]    id_alu_opcode,
    input  logic          id_alu_src,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    // pipeline control
    input  logic          stall,
    input  logic          flush,
    // forward sources
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    // EX stage outputs
    output logic          ex_valid,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    ex_alu_opcode,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          load_use_hazard
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [2:0]    alu_opcode;
        logic          alu_src;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } stage_t;

    stage_t        r_ex;
    stage_t        w_id;
    logic          w_hazard;
    logic          w_load_use;
    logic          w_id_reads_ex;
    logic          w_bubble;
    logic          w_load;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

    // Control bits are gated by id_valid so an empty ID slot can never write state downstream.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_id            = '0;
        w_id.valid      = id_valid;
        w_id.rs_data    = id_rs_data;
        w_id.rt_data    = id_rt_data;
        w_id.imm        = id_imm;
        w_id.rs         = id_rs;
        w_id.rt         = id_rt;
        w_id.rd         = id_rd;
        w_id.alu_opcode = id_alu_opcode;
        w_id.alu_src    = id_alu_src;
        w_id.reg_write  = id_valid & id_reg_write;
        w_id.mem_read   = id_valid & id_mem_read;
        w_id.mem_write  = id_valid & id_mem_write;
        w_id.mem_to_reg = id_valid & id_mem_to_reg;
    end

    assign w_id_reads_ex = (r_ex.rd == id_rs) || (r_ex.rd == id_rt);
    assign w_load_use    = r_ex.valid && r_ex.mem_read && (r_ex.rd != '0)
                           && id_valid && w_id_reads_ex;

`ifdef FWD_EN
    logic w_rs_exmem;
    logic w_rs_memwb;
    logic w_rt_exmem;
    logic w_rt_memwb;

    assign w_rs_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_ex.rs);
    assign w_rs_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_ex.rs);
    assign w_rt_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_ex.rt);
    assign w_rt_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_ex.rt);

    // EX/MEM is the younger producer, so it is checked before MEM/WB.
    always_comb begin
        w_fwd_rs = r_ex.rs_data;
        if (w_rs_exmem) begin
            w_fwd_rs = exmem_result;
        end else if (w_rs_memwb) begin
            w_fwd_rs = memwb_result;
        end
    end

    always_comb begin
        w_fwd_rt = r_ex.rt_data;
        if (w_rt_exmem) begin
            w_fwd_rt = exmem_result;
        end else if (w_rt_memwb) begin
            w_fwd_rt = memwb_result;
        end
    end

    assign w_hazard = w_load_use;
`else
    logic w_raw_ex;
    logic w_raw_exmem;
    logic w_unused_fwd;

    // Without forwarding, any producer still in EX or EX/MEM must drain; MEM/WB is
    // covered by the write-first register file.
    assign w_raw_ex    = r_ex.valid && r_ex.reg_write && (r_ex.rd != '0)
                         && id_valid && w_id_reads_ex;
    assign w_raw_exmem = exmem_reg_write && (exmem_rd != '0) && id_valid
                         && ((exmem_rd == id_rs) || (exmem_rd == id_rt));

    assign w_fwd_rs = r_ex.rs_data;
    assign w_fwd_rt = r_ex.rt_data;
    assign w_hazard = w_load_use || w_raw_ex || w_raw_exmem;

    assign w_unused_fwd = ^{memwb_reg_write, memwb_rd, memwb_result, exmem_result,
                            r_ex.rs, r_ex.rt};
`endif

    // Priority flush > stall > hazard > load; a stall also holds a pending bubble.
    assign w_bubble = flush || (!stall && w_hazard);
    assign w_load   = !flush && !stall && !w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_n) begin
            r_ex <= '0;
        end else if (w_bubble) begin
            r_ex <= '0;
        end else if (w_load) begin
            r_ex <= w_id;
        end
    end

    assign ex_valid        = r_ex.valid;
    assign alu_a           = w_fwd_rs;
    assign alu_b           = r_ex.alu_src ? r_ex.imm : w_fwd_rt;
    assign ex_alu_opcode   = r_ex.alu_opcode;
    assign ex_store_data   = w_fwd_rt;
    assign ex_rd           = r_ex.rd;
    assign ex_reg_write    = r_ex.reg_write;
    assign ex_mem_read     = r_ex.mem_read;
    assign ex_mem_write    = r_ex.mem_write;
    assign ex_mem_to_reg   = r_ex.mem_to_reg;
    assign load_use_hazard = w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes expected EX contents, negedge monitor pops and compares.
// Covers both FWD_EN builds; the config-specific sections follow the same macro.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [2:0]    id_alu_opcode;
    logic          id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          stall, flush;
    logic          exmem_reg_write, memwb_reg_write;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [DW-1:0] exmem_result, memwb_result;
    logic          ex_valid;
    logic [DW-1:0] alu_a, alu_b, ex_store_data;
    logic [2:0]    ex_alu_opcode;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic          load_use_hazard;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_opcode(id_alu_opcode),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .ex_alu_opcode(ex_alu_opcode),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] store;
        logic [2:0]    op;
        logic [RW-1:0] rd;
        logic          rw, mr, mw, m2r;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_id(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic [RW-1:0] rd, input logic [DW-1:0] rsd,
                          input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                          input logic [2:0] op, input logic src, input logic rw,
                          input logic mr, input logic mw, input logic m2r);
        id_valid = v;   id_rs = rs;   id_rt = rt;   id_rd = rd;
        id_rs_data = rsd;   id_rt_data = rtd;   id_imm = imm;
        id_alu_opcode = op;   id_alu_src = src;
        id_reg_write = rw;   id_mem_read = mr;   id_mem_write = mw;   id_mem_to_reg = m2r;
    endtask

    task automatic set_fwd(input logic erw, input logic [RW-1:0] erd, input logic [DW-1:0] eres,
                           input logic mrw, input logic [RW-1:0] mrd, input logic [DW-1:0] mres);
        exmem_reg_write = erw;   exmem_rd = erd;   exmem_result = eres;
        memwb_reg_write = mrw;   memwb_rd = mrd;   memwb_result = mres;
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] st,
                        input logic [2:0] op, input logic [RW-1:0] rd, input logic rw,
                        input logic mr, input logic mw, input logic m2r);
        exp_t e;
        e.a = a;   e.b = b;   e.store = st;   e.op = op;   e.rd = rd;
        e.rw = rw;   e.mr = mr;   e.mw = mw;   e.m2r = m2r;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle EX presents a valid instruction, one expectation is consumed.
    always @(negedge clk) begin
        if (rst_n && ex_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ex_valid: got ex_valid=1 rd=%0d expected empty EX (t=%0t)",
                         ex_rd, $time);
            end else begin
                m_e = sb_q.pop_front();
                check("sb_alu_a", alu_a, m_e.a);
                check("sb_alu_b", alu_b, m_e.b);
                check("sb_store", ex_store_data, m_e.store);
                check("sb_opcode", {29'd0, ex_alu_opcode}, {29'd0, m_e.op});
                check("sb_rd", {27'd0, ex_rd}, {27'd0, m_e.rd});
                check("sb_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                      {28'd0, m_e.rw, m_e.mr, m_e.mw, m_e.m2r});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        stall = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_opcode", {29'd0, ex_alu_opcode}, 32'd0);
        check("rst_hazard", {31'd0, load_use_hazard}, 32'd0);

        // Pass-through: register operands, immediate operand, store, then an empty slot.
        set_id(1, 1, 2, 3, 32'd5, 32'd7, 32'h100, 3'b001, 0, 1, 0, 0, 0);
        push(32'd5, 32'd7, 32'd7, 3'b001, 3, 1, 0, 0, 0);
        tick();
        set_id(1, 4, 5, 6, 32'h10, 32'h20, 32'hFFFF_FFFC, 3'b000, 1, 1, 0, 0, 0);
        push(32'h10, 32'hFFFF_FFFC, 32'h20, 3'b000, 6, 1, 0, 0, 0);
        #1;
        check("no_raw_hazard", {31'd0, load_use_hazard}, 32'd0);
        tick();
        set_id(1, 7, 9, 0, 32'h1000, 32'hDEAD, 32'd8, 3'b000, 1, 0, 0, 1, 0);
        push(32'h1000, 32'd8, 32'hDEAD, 3'b000, 0, 0, 0, 1, 0);
        tick();
        set_id(0, 3, 3, 3, 32'h1, 32'h2, 32'h3, 3'b010, 0, 1, 1, 0, 1);
        tick();
        #1;
        check("invalid_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("invalid_gated_rw", {31'd0, ex_reg_write}, 32'd0);

`ifdef FWD_EN
        // Forward priority on rs: EX/MEM over MEM/WB, then MEM/WB alone, then index 0.
        set_id(1, 3, 10, 11, 32'hAAAA, 32'hBBBB, 32'd0, 3'b010, 0, 1, 0, 0, 0);
        push(32'h11, 32'hBBBB, 32'hBBBB, 3'b010, 11, 1, 0, 0, 0);
        tick();
        set_fwd(1, 3, 32'h11, 1, 3, 32'h22);
        stall = 1'b1;
        push(32'h22, 32'hBBBB, 32'hBBBB, 3'b010, 11, 1, 0, 0, 0);
        tick();
        stall = 1'b0;
        set_fwd(0, 3, 32'h11, 1, 3, 32'h22);
        set_id(1, 0, 0, 12, 32'h33, 32'h44, 32'd0, 3'b011, 0, 1, 0, 0, 0);
        push(32'h33, 32'h44, 32'h44, 3'b011, 12, 1, 0, 0, 0);
        tick();
        set_fwd(1, 0, 32'hE0, 1, 0, 32'hE1);
        set_id(1, 12, 13, 14, 32'h1, 32'h2, 32'd7, 3'b100, 1, 1, 0, 0, 0);
        push(32'h55, 32'd7, 32'h66, 3'b100, 14, 1, 0, 0, 0);
        tick();
        set_fwd(1, 12, 32'h55, 1, 13, 32'h66);
        set_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        tick();
        set_fwd(0, 0, 0, 0, 0, 0);

        // Load-use: lw r8 in EX, add reading r8 in ID -> one bubble, then MEM/WB forward.
        set_id(1, 1, 8, 8, 32'h200, 32'h5, 32'd4, 3'b000, 1, 1, 1, 0, 1);
        push(32'h200, 32'd4, 32'h5, 3'b000, 8, 1, 1, 0, 1);
        tick();
        set_id(1, 8, 2, 9, 32'h0, 32'h3, 32'd0, 3'b000, 0, 1, 0, 0, 0);
        #1;
        check("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
        tick();
        #1;
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        check("lu_released", {31'd0, load_use_hazard}, 32'd0);
        push(32'h77, 32'd3, 32'd3, 3'b000, 9, 1, 0, 0, 0);
        tick();
        set_fwd(0, 0, 0, 1, 8, 32'h77);
        set_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        tick();
        set_fwd(0, 0, 0, 0, 0, 0);
`else
        // No forwarding: RAW on EX, then on EX/MEM, stalls; forward inputs are ignored.
        set_id(1, 1, 2, 4, 32'h10, 32'h20, 32'd0, 3'b000, 0, 1, 0, 0, 0);
        push(32'h10, 32'h20, 32'h20, 3'b000, 4, 1, 0, 0, 0);
        tick();
        set_id(1, 4, 6, 7, 32'h40, 32'h60, 32'd0, 3'b001, 0, 1, 0, 0, 0);
        #1;
        check("raw_ex_hazard", {31'd0, load_use_hazard}, 32'd1);
        tick();
        #1;
        check("raw_bubble", {31'd0, ex_valid}, 32'd0);
        set_fwd(1, 4, 32'hBAD0, 0, 0, 0);
        #1;
        check("raw_exmem_hazard", {31'd0, load_use_hazard}, 32'd1);
        tick();
        set_fwd(1, 5, 32'hBAD1, 1, 4, 32'hBAD2);
        #1;
        check("raw_clear", {31'd0, load_use_hazard}, 32'd0);
        push(32'h40, 32'h60, 32'h60, 3'b001, 7, 1, 0, 0, 0);
        tick();
        set_fwd(1, 4, 32'hBAD3, 1, 6, 32'hBAD4);
        set_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        tick();
        set_fwd(0, 0, 0, 0, 0, 0);
`endif

        // Stall holds EX for three edges; flush beats stall on the next edge.
        set_id(1, 21, 22, 20, 32'h1234, 32'h5678, 32'h9, 3'b010, 0, 1, 0, 0, 0);
        push(32'h1234, 32'h5678, 32'h5678, 3'b010, 20, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            set_id(1, 23, 24, 25, 32'h1111, 32'h2222, 32'h3, 3'b100, 1, 0, 1, 1, 0);
            push(32'h1234, 32'h5678, 32'h5678, 3'b010, 20, 1, 0, 0, 0);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        #1;
        check("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("flush_opcode", {29'd0, ex_alu_opcode}, 32'd0);

        // Asynchronous reset mid-cycle drops the in-flight instruction before any edge.
        set_id(1, 26, 27, 28, 32'hCAFE, 32'hF00D, 32'd0, 3'b001, 0, 1, 0, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        check("pre_reset_alu_a", alu_a, 32'hCAFE);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("mid_rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("mid_rst_alu_a", alu_a, 32'd0);
        check("mid_rst_alu_b", alu_b, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        check("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
